// File: rtl/sr_latch_driver_pkg.sv
// Shared types and constants for the SR latch command driver.
package sr_latch_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    // Dead time must cover the readback synchronizer latency.
    localparam int unsigned GAP_W_MIN   = 2;
    localparam int unsigned PULSE_W_MIN = 1;

    function automatic int unsigned cnt_width(input int unsigned pw, input int unsigned gw);
        int unsigned m;
        m = (pw > gw) ? pw : gw;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sr_latch_driver_sync_2ff.sv
// Two-flop synchronizer for latch readback; clears to 0 on synchronous reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sr_latch_driver.sv
// Drives a fixed-width, mutually exclusive set/reset pulse into an external SR latch,
// waits out a dead time, then confirms the latch state through synchronized readback.
module sr_latch_driver
    import sr_latch_driver_pkg::*;
#(
    parameter int unsigned PULSE_W = 4,
    parameter int unsigned GAP_W   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cmd_valid,
    input  logic cmd_set,
    output logic cmd_ready,
    output logic s_out,
    output logic r_out,
    input  logic q_in,
    input  logic qb_in,
    output logic busy,
    output logic done,
    output logic fault,
    input  logic fault_clr
);

    localparam int unsigned CNT_W = cnt_width(PULSE_W, GAP_W);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_W - 1);

    if (GAP_W < GAP_W_MIN) begin : g_bad_gap
        $error("sr_latch_driver: GAP_W must be at least %0d", GAP_W_MIN);
    end
    if (PULSE_W < PULSE_W_MIN) begin : g_bad_pulse
        $error("sr_latch_driver: PULSE_W must be at least %0d", PULSE_W_MIN);
    end

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             tgt, tgt_nx;
    logic             s_nx, r_nx, done_nx, busy_nx, fault_nx;
    logic             qs, qbs;
    logic             mismatch;

    sync_2ff u_sync_q (
        .clk (clk),
        .rst (rst),
        .d   (q_in),
        .q   (qs)
    );

    sync_2ff u_sync_qb (
        .clk (clk),
        .rst (rst),
        .d   (qb_in),
        .q   (qbs)
    );

    // Latch must read back as the target with complementary qb; q==qb always fails.
    assign mismatch  = (qs != tgt) || (qbs != ~tgt);
    assign cmd_ready = (state == ST_IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            tgt   <= 1'b0;
            s_out <= 1'b0;
            r_out <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
            fault <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            tgt   <= tgt_nx;
            s_out <= s_nx;
            r_out <= r_nx;
            done  <= done_nx;
            busy  <= busy_nx;
            fault <= fault_nx;
        end
    end

    // Drives default low so only one of s/r can ever be requested, and only from PULSE.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        tgt_nx   = tgt;
        s_nx     = 1'b0;
        r_nx     = 1'b0;
        done_nx  = 1'b0;
        fault_nx = fault_clr ? 1'b0 : fault;

        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    tgt_nx   = cmd_set;
                    cnt_nx   = '0;
                    s_nx     = cmd_set;
                    r_nx     = ~cmd_set;
                    state_nx = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (cnt == PULSE_LAST) begin
                    cnt_nx   = '0;
                    state_nx = ST_GAP;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                    s_nx   = tgt;
                    r_nx   = ~tgt;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nx   = '0;
                    done_nx  = 1'b1;
                    state_nx = ST_CHECK;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_CHECK: begin
                state_nx = ST_IDLE;
                if (mismatch) begin
                    fault_nx = 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        busy_nx = (state_nx != ST_IDLE);
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver with a behavioural SR latch looped back on q/qb.
module tb_sr_latch_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0;
    logic cmd_set = 1'b0;
    logic fault_clr = 1'b0;
    logic cmd_ready, s_out, r_out, busy, done, fault;
    logic q_in, qb_in;

    logic lq = 1'b0;
    logic force_q0 = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    sr_latch_driver dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_set   (cmd_set),
        .cmd_ready (cmd_ready),
        .s_out     (s_out),
        .r_out     (r_out),
        .q_in      (q_in),
        .qb_in     (qb_in),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .fault_clr (fault_clr)
    );

    // Behavioural latch with one unit of gate delay.
    always @(s_out or r_out) begin
        #1;
        if (s_out && !r_out) lq = 1'b1;
        else if (r_out && !s_out) lq = 1'b0;
    end
    assign q_in  = force_q0 ? 1'b0 : lq;
    assign qb_in = ~lq;

    always @(negedge clk) begin
        n_chk++;
        if (s_out & r_out) begin
            n_fail++;
            $display("FAIL s_and_r: s_out=%0b r_out=%0b required not both high (t=%0t)", s_out, r_out, $time);
        end
    end

    typedef struct {
        logic       rst;
        logic       valid;
        logic       set;
        logic       clr;
        logic [6:0] exp;   // {s_out, r_out, done, busy, cmd_ready, fault, q_in}
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input logic r, input logic v, input logic s, input logic c,
                                input logic [6:0] e);
        vec_t t;
        t.rst = r; t.valid = v; t.set = s; t.clr = c; t.exp = e;
        return t;
    endfunction

    task automatic step;
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One full command from an idle state; tallies drive and done over the command window.
    task automatic do_cmd(input logic set, input logic clr_at_check);
        int w, pulse_s, pulse_r, gap_drv, dn;
        w = 0; pulse_s = 0; pulse_r = 0; gap_drv = 0; dn = 0;
        while (!cmd_ready && w < 20) begin
            step;
            w++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_set   = set;
        for (int i = 1; i <= 7; i++) begin
            step;
            cmd_valid = 1'b0;
            cmd_set   = ~set;
            if (i <= 4) begin
                pulse_s += int'(s_out);
                pulse_r += int'(r_out);
            end else begin
                gap_drv += int'(s_out | r_out);
            end
            dn += int'(done);
            if (i == 7) begin
                chk("done_at_check", 32'(done), 32'd1);
                if (clr_at_check) fault_clr = 1'b1;
            end
        end
        step;
        fault_clr = 1'b0;
        chk("pulse_s_cycles", 32'(pulse_s), set ? 32'd4 : 32'd0);
        chk("pulse_r_cycles", 32'(pulse_r), set ? 32'd0 : 32'd4);
        chk("gap_drive", 32'(gap_drv), 32'd0);
        chk("done_count", 32'(dn), 32'd1);
        chk("ready_after_cmd", {31'd0, cmd_ready}, 32'd1);
        chk("busy_after_cmd", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, to, last;
        logic exp_set, prev_set;

        for (int i = 0; i < 3; i++) tbl[i] = mk(1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000);
        tbl[3] = mk(1'b0, 1'b1, 1'b1, 1'b0, 7'b0000100);
        for (int i = 4; i < 8; i++) tbl[i] = mk(1'b0, 1'b0, 1'b0, 1'b0, 7'b1001001);
        for (int i = 8; i < 10; i++) tbl[i] = mk(1'b0, 1'b0, 1'b0, 1'b0, 7'b0001001);
        tbl[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 7'b0011001);
        tbl[11] = mk(1'b0, 1'b1, 1'b0, 1'b0, 7'b0000101);
        for (int i = 12; i < 16; i++) tbl[i] = mk(1'b0, 1'b0, 1'b1, 1'b0, 7'b0101000);
        for (int i = 16; i < 18; i++) tbl[i] = mk(1'b0, 1'b0, 1'b1, 1'b0, 7'b0001000);
        tbl[18] = mk(1'b0, 1'b0, 1'b1, 1'b0, 7'b0011000);
        tbl[19] = mk(1'b0, 1'b0, 1'b0, 1'b0, 7'b0000100);

        // Reset, set command, then reset command, cycle by cycle.
        for (int i = 0; i < 20; i++) begin
            step;
            rst       = tbl[i].rst;
            cmd_valid = tbl[i].valid;
            cmd_set   = tbl[i].set;
            fault_clr = tbl[i].clr;
            #1;
            chk($sformatf("vec%0d", i), {25'd0, s_out, r_out, done, busy, cmd_ready, fault, q_in},
                {25'd0, tbl[i].exp});
        end
        chk("qb_after_reset_cmd", {31'd0, qb_in}, 32'd1);

        // cmd_valid held high with alternating targets.
        exp_set = 1'b1; prev_set = 1'b0; k = 0; to = 0; last = 0;
        while (k < 4 && to < 60) begin
            step;
            to++;
            chk("ready_while_busy", {31'd0, cmd_ready & busy}, 32'd0);
            if (cmd_ready) begin
                if (k > 0) begin
                    chk("accept_period", 32'(cyc - last), 32'd8);
                    chk("q_follows_cmd", {31'd0, q_in}, {31'd0, prev_set});
                end
                last = cyc;
                if (k < 3) begin
                    cmd_valid = 1'b1;
                    cmd_set   = exp_set;
                    prev_set  = exp_set;
                    exp_set   = ~exp_set;
                end else begin
                    cmd_valid = 1'b0;
                end
                k++;
            end
        end
        chk("stream_complete", 32'(k), 32'd4);
        cmd_valid = 1'b0;

        // Readback stuck low: fault is sticky, clearable, and set wins over clear.
        force_q0 = 1'b1;
        do_cmd(1'b1, 1'b0);
        chk("fault_set", {31'd0, fault}, 32'd1);
        step;
        chk("fault_sticky", {31'd0, fault}, 32'd1);
        fault_clr = 1'b1;
        step;
        fault_clr = 1'b0;
        chk("fault_cleared", {31'd0, fault}, 32'd0);
        do_cmd(1'b1, 1'b1);
        chk("fault_set_beats_clr", {31'd0, fault}, 32'd1);
        fault_clr = 1'b1;
        step;
        fault_clr = 1'b0;
        chk("fault_cleared_again", {31'd0, fault}, 32'd0);
        force_q0 = 1'b0;

        // Reset during the second pulse cycle aborts the command cleanly.
        cmd_valid = 1'b1;
        cmd_set   = 1'b1;
        step;
        cmd_valid = 1'b0;
        chk("abort_pulse1", {31'd0, s_out}, 32'd1);
        step;
        chk("abort_pulse2", {31'd0, s_out}, 32'd1);
        rst = 1'b1;
        #1;
        chk("ready_low_in_rst", {31'd0, cmd_ready}, 32'd0);
        step;
        rst = 1'b0;
        #1;
        chk("abort_outputs", {27'd0, s_out, r_out, busy, done, fault}, 32'd0);
        chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);
        for (int i = 0; i < 9; i++) begin
            step;
            chk("no_done_after_abort", {30'd0, done, busy}, 32'd0);
        end

        // Redundant set commands still issue full pulses.
        do_cmd(1'b1, 1'b0);
        chk("redundant1_q", {31'd0, q_in}, 32'd1);
        chk("redundant1_fault", {31'd0, fault}, 32'd0);
        do_cmd(1'b1, 1'b0);
        chk("redundant2_q", {31'd0, q_in}, 32'd1);
        chk("redundant2_fault", {31'd0, fault}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
